jstk_reader: RTL and testbench

Polls the PmodJSTK joystick over SPI and produces the 4-bit direction vector `jstkPos` that drives player movement and shooting in the game core. It is the producer end of the `jstkPos` interface: it decodes raw 10-bit X/Y readings into left/right/up/down flags and pulses them once per poll. It also exposes raw axis values and buttons for debug LEDs and the seven-segment display.

---
 rtl/jstk_pkg.sv | 32 +++
 rtl/spi_byte_shifter.sv | 69 ++++++
 rtl/jstk_reader.sv | 134 +++++++++++++
 tb/tb_jstk_reader.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/jstk_pkg.sv
// rtl/jstk_pkg.sv - shared types, constants and direction decode for the joystick reader
package jstk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP,
        ST_DONE
    } jstk_state_t;

    localparam int         NUM_BYTES = 5;
    localparam logic [7:0] CMD_BYTE  = 8'h80;

    localparam int POS_UP    = 0;
    localparam int POS_DOWN  = 1;
    localparam int POS_LEFT  = 2;
    localparam int POS_RIGHT = 3;

    // Strict compares: a reading exactly on a threshold counts as centred.
    function automatic logic [3:0] decode_pos(input logic [9:0] x, input logic [9:0] y,
                                              input logic [9:0] th_lo, input logic [9:0] th_hi);
        logic [3:0] p;
        p            = '0;
        p[POS_RIGHT] = (x > th_hi);
        p[POS_LEFT]  = (x < th_lo);
        p[POS_UP]    = (y > th_hi);
        p[POS_DOWN]  = (y < th_lo);
        return p;
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// rtl/spi_byte_shifter.sv - 8-bit SPI mode-0 shift engine, runs while i_run is high
module spi_byte_shifter #(
    parameter int CLK_DIV = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_run,
    input  logic       i_load,
    input  logic [7:0] i_tx,
    input  logic       i_miso,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic [7:0] o_rx,
    output logic       o_done
);
    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic          r_sclk;
    logic          r_mosi;
    logic [7:0]    r_tx;
    logic [7:0]    r_rx;
    logic          w_edge;

    assign w_edge = i_run && (r_cnt == CW'(CLK_DIV - 1));
    // Done coincides with the eighth falling edge so the caller can leave SHIFT on that edge.
    assign o_done = w_edge && r_sclk && (r_bit == 3'd7);
    assign o_sclk = r_sclk;
    assign o_mosi = r_mosi;
    assign o_rx   = r_rx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_bit  <= '0;
            r_sclk <= 1'b0;
            r_mosi <= 1'b0;
            r_tx   <= '0;
            r_rx   <= '0;
        end else begin
            if (!i_run) begin
                r_cnt  <= '0;
                r_bit  <= '0;
                r_sclk <= 1'b0;
            end else if (w_edge) begin
                r_cnt  <= '0;
                r_sclk <= ~r_sclk;
                if (!r_sclk) begin
                    r_rx <= {r_rx[6:0], i_miso};
                end else begin
                    r_bit <= r_bit + 3'd1;
                    if (r_bit != 3'd7) begin
                        r_mosi <= r_tx[6];
                        r_tx   <= {r_tx[6:0], 1'b0};
                    end
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            // A load presents the MSB on mosi before the first rising edge.
            if (i_load) begin
                r_tx   <= i_tx;
                r_mosi <= i_tx[7];
            end
        end
    end

endmodule

// File: rtl/jstk_reader.sv
// rtl/jstk_reader.sv - PmodJSTK poller producing direction pulses and raw axis/button values
module jstk_reader
    import jstk_pkg::*;
#(
    parameter int CLK_DIV     = 50,
    parameter int CS_SETUP    = 1500,
    parameter int BYTE_GAP    = 1000,
    parameter int POLL_PERIOD = 10_000_000,
    parameter int TH_LO       = 256,
    parameter int TH_HI       = 768
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic [3:0] jstkPos,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic [2:0] btn,
    output logic       frame_valid
);
    localparam int PW   = $clog2(POLL_PERIOD);
    localparam int TMAX = (CS_SETUP > BYTE_GAP) ? CS_SETUP : BYTE_GAP;
    localparam int TW   = $clog2(TMAX + 1);

    jstk_state_t r_state;
    logic [PW-1:0] r_poll;
    logic [TW-1:0] r_tmr;
    logic [2:0]    r_byte;
    logic          r_started;
    logic [9:0]    r_xt;
    logic [9:0]    r_yt;

    logic       w_start;
    logic       w_done;
    logic       w_load;
    logic [7:0] w_tx;
    logic [7:0] w_rx;

    assign w_start = (r_state == ST_IDLE) && en &&
                     (!r_started || (r_poll == PW'(POLL_PERIOD - 1)));
    assign w_load  = w_start || w_done;
    assign w_tx    = w_start ? CMD_BYTE : 8'h00;

    spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shift (
        .clk    (clk),
        .rst    (rst),
        .i_run  (r_state == ST_SHIFT),
        .i_load (w_load),
        .i_tx   (w_tx),
        .i_miso (miso),
        .o_sclk (sclk),
        .o_mosi (mosi),
        .o_rx   (w_rx),
        .o_done (w_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_poll      <= '0;
            r_tmr       <= '0;
            r_byte      <= '0;
            r_started   <= 1'b0;
            r_xt        <= 10'd512;
            r_yt        <= 10'd512;
            cs_n        <= 1'b1;
            jstkPos     <= '0;
            x_pos       <= 10'd512;
            y_pos       <= 10'd512;
            btn         <= '0;
            frame_valid <= 1'b0;
        end else begin
            jstkPos     <= '0;
            frame_valid <= 1'b0;

            // Poll period is measured from frame start; idle with en low holds it at zero.
            if (w_start || (r_state == ST_IDLE && !en))
                r_poll <= '0;
            else
                r_poll <= r_poll + PW'(1);

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state   <= ST_SETUP;
                        r_started <= 1'b1;
                        cs_n      <= 1'b0;
                        r_tmr     <= '0;
                        r_byte    <= '0;
                    end
                end
                ST_SETUP: begin
                    if (r_tmr == TW'(CS_SETUP - 1)) r_state <= ST_SHIFT;
                    else                            r_tmr   <= r_tmr + TW'(1);
                end
                ST_SHIFT: begin
                    if (w_done) begin
                        case (r_byte)
                            3'd0:    r_xt[7:0] <= w_rx;
                            3'd1:    r_xt[9:8] <= w_rx[1:0];
                            3'd2:    r_yt[7:0] <= w_rx;
                            3'd3:    r_yt[9:8] <= w_rx[1:0];
                            default: ;
                        endcase
                        if (r_byte == 3'(NUM_BYTES - 1)) begin
                            r_state     <= ST_DONE;
                            cs_n        <= 1'b1;
                            x_pos       <= r_xt;
                            y_pos       <= r_yt;
                            btn         <= w_rx[2:0];
                            frame_valid <= 1'b1;
                            jstkPos     <= decode_pos(r_xt, r_yt, 10'(TH_LO), 10'(TH_HI));
                        end else begin
                            r_state <= ST_GAP;
                            r_tmr   <= '0;
                            r_byte  <= r_byte + 3'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_tmr == TW'(BYTE_GAP - 1)) r_state <= ST_SHIFT;
                    else                            r_tmr   <= r_tmr + TW'(1);
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jstk_reader.sv
// tb/tb_jstk_reader.sv - scoreboard bench for jstk_reader with a PmodJSTK slave model
module tb_jstk_reader;
    localparam int CLK_DIV   = 2;
    localparam int CS_SETUP  = 10;
    localparam int BYTE_GAP  = 6;
    localparam int POLL      = 300;
    localparam int FRAME_GAP = CS_SETUP + 80 * CLK_DIV + 4 * BYTE_GAP;

    typedef struct packed {
        logic [3:0] pos;
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       miso;
    logic       sclk, mosi, cs_n, frame_valid;
    logic [3:0] jstkPos;
    logic [9:0] x_pos, y_pos;
    logic [2:0] btn;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int frames = 0;
    int fv_cyc = 0;
    int cs_fall_cyc = 0;
    int first_rise = -1;
    logic cs_q = 1'b1;
    logic [39:0] sframe = '0;
    logic [39:0] mosi_cap = '0;
    int scnt = 0;
    exp_t exp_q[$];

    jstk_reader #(
        .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .BYTE_GAP(BYTE_GAP),
        .POLL_PERIOD(POLL), .TH_LO(256), .TH_HI(768)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .miso(miso),
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .jstkPos(jstkPos),
        .x_pos(x_pos), .y_pos(y_pos), .btn(btn), .frame_valid(frame_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, req, req);
        end
    endtask

    function automatic logic [39:0] mk(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b);
        return {x[7:0], 6'b101101, x[9:8], y[7:0], 6'b110011, y[9:8], 5'b10110, b};
    endfunction

    // Slave: next bit is presented right after each rising edge, first bit while cs_n is low.
    always @(posedge sclk or posedge cs_n) begin
        if (cs_n) begin
            scnt <= 0;
        end else begin
            scnt     <= scnt + 1;
            mosi_cap <= {mosi_cap[38:0], mosi};
        end
    end

    always_comb begin
        miso = 1'b0;
        if (scnt < 40) miso = sframe[6'(39 - scnt)];
    end

    always @(negedge clk) begin
        exp_t e;
        if (cs_q && !cs_n) begin
            cs_fall_cyc = cyc;
            first_rise  = -1;
        end
        if (!cs_n && sclk && first_rise < 0) first_rise = cyc;
        cs_q = cs_n;
        if (frame_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame: got jstkPos=%b required no frame", jstkPos);
            end else begin
                e = exp_q.pop_front();
                chk("jstkPos", longint'(jstkPos), longint'(e.pos));
                chk("x_pos", longint'(x_pos), longint'(e.x));
                chk("y_pos", longint'(y_pos), longint'(e.y));
                chk("btn", longint'(btn), longint'(e.b));
                chk("frame_len", longint'(cyc - cs_fall_cyc), longint'(FRAME_GAP));
                chk("first_sclk_rise", longint'(first_rise - cs_fall_cyc), longint'(CS_SETUP + CLK_DIV));
                chk("mosi_bytes", longint'(mosi_cap), 64'h80_0000_0000);
            end
            fv_cyc = cyc;
            frames++;
        end else if (jstkPos != 4'b0) begin
            total++;
            bad++;
            $display("FAIL stray_pulse: got jstkPos=%b required 0000 outside frame_valid", jstkPos);
        end
    end

    task automatic wait_frame();
        int n0;
        n0 = frames;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk);
            if (frames != n0) return;
        end
        total++;
        bad++;
        $display("FAIL frame_timeout: got no frame_valid required one within 2000 cycles");
    endtask

    task automatic wait_cs_low();
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (!cs_n) return;
        end
        total++;
        bad++;
        $display("FAIL cs_timeout: got cs_n high required a frame start within 2000 cycles");
    endtask

    task automatic count_cs_low(input string nm, input int n);
        int lows;
        lows = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (!cs_n) lows++;
        end
        chk(nm, longint'(lows), 0);
    endtask

    int         vx[9] = '{900, 100, 256, 1023, 255, 769, 900, 900, 900};
    int         vy[9] = '{512, 1000, 768, 0, 769, 255, 300, 300, 300};
    logic [2:0] vb[9] = '{3'b000, 3'b101, 3'b000, 3'b111, 3'b010, 3'b000, 3'b001, 3'b001, 3'b001};
    logic [3:0] vp[9] = '{4'b1000, 4'b0101, 4'b0000, 4'b1010, 4'b0101, 4'b1010, 4'b1000, 4'b1000, 4'b1000};

    initial begin
        int prev;
        prev = 0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", longint'(cs_n), 1);
        chk("rst_sclk", longint'(sclk), 0);
        chk("rst_mosi", longint'(mosi), 0);
        chk("rst_jstkPos", longint'(jstkPos), 0);
        chk("rst_x_pos", longint'(x_pos), 512);
        chk("rst_y_pos", longint'(y_pos), 512);
        chk("rst_btn", longint'(btn), 0);
        chk("rst_frame_valid", longint'(frame_valid), 0);
        rst = 1'b1;
        count_cs_low("idle_en_low", 20);

        for (int i = 0; i < 9; i++) begin
            sframe = mk(10'(vx[i]), 10'(vy[i]), vb[i]);
            exp_q.push_back('{pos: vp[i], x: 10'(vx[i]), y: 10'(vy[i]), b: vb[i]});
            en = 1'b1;
            wait_frame();
            if (i > 0) chk("poll_spacing", longint'(fv_cyc - prev), longint'(POLL));
            prev = fv_cyc;
            @(negedge clk);
        end

        wait_cs_low();
        repeat (95) @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_cs_n", longint'(cs_n), 1);
        chk("midrst_sclk", longint'(sclk), 0);
        chk("midrst_x_pos", longint'(x_pos), 512);
        chk("midrst_jstkPos", longint'(jstkPos), 0);
        chk("midrst_frame_valid", longint'(frame_valid), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        count_cs_low("after_rst_idle", 400);

        sframe = mk(10'd100, 10'd512, 3'b011);
        exp_q.push_back('{pos: 4'b0100, x: 10'd100, y: 10'd512, b: 3'b011});
        en = 1'b1;
        wait_cs_low();
        repeat (50) @(negedge clk);
        en = 1'b0;
        wait_frame();
        count_cs_low("after_en_drop", 400);

        chk("queue_empty", longint'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
